// File: rtl/step_debounce_pulse_pkg.sv
// Shared types for the step-button debounce stage.
// State encoding and default qualification length.
package step_debounce_pulse_pkg;

  localparam int unsigned STABLE_COUNT_DEF = 1000000;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    PRESS_CHK   = 2'b01,
    PRESSED     = 2'b11,
    RELEASE_CHK = 2'b10
  } state_t;

  function automatic logic is_busy(state_t s);
    return (s == PRESS_CHK) || (s == RELEASE_CHK);
  endfunction

endpackage

// File: rtl/step_debounce_pulse_if.sv
// Button-side bundle of the debounce stage.
// Raw input in, conditioned level/pulse/count out.
interface step_debounce_pulse_if #(
  parameter int unsigned PCNT_WIDTH = 8
);
  logic                  btn_in;
  logic                  btn_level;
  logic                  btn_pulse;
  logic [PCNT_WIDTH-1:0] press_count;
  logic                  busy;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_pulse,
    input  press_count,
    input  busy
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_pulse,
    output press_count,
    output busy
  );
endinterface

// File: rtl/step_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Reusable for any single-bit async input.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_debounce_pulse.sv
// Debounces the step button: clean level, one-cycle
// press pulse, wrapping press counter and busy flag.
module step_debounce_pulse
  import step_debounce_pulse_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = STABLE_COUNT_DEF,
  parameter int unsigned PCNT_WIDTH   = 8
) (
  input logic                 clk,
  input logic                 reset,
  step_debounce_pulse_if.slave bus
);

  localparam int unsigned CNT_WIDTH = $clog2(STABLE_COUNT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [PCNT_WIDTH-1:0] PCNT_ONE = PCNT_WIDTH'(1);

  logic sync;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  pulse_q, pulse_d;
  logic                  busy_q, busy_d;
  logic [PCNT_WIDTH-1:0] count_q, count_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_in),
    .q     (sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (sync) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          level_d = 1'b1;
          pulse_d = 1'b1;
          count_d = count_q + PCNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        level_d = 1'b1;
        if (!sync) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        // a bounce back high keeps the press without re-pulsing
        if (sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    busy_d = is_busy(state_d);
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_pulse   = pulse_q;
  assign bus.press_count = count_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_step_debounce_pulse.sv
// Randomised and directed bench for step_debounce_pulse
// against a run-length reference model.
module tb_step_debounce_pulse;

  localparam int SC = 4;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  step_debounce_pulse_if #(.PCNT_WIDTH(PW)) bus ();

  step_debounce_pulse #(
    .STABLE_COUNT (SC),
    .PCNT_WIDTH   (PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model: level flips after SC+1 consecutive synced samples disagree
  int m_s1, m_s2, m_level, m_run, m_pulse, m_busy, m_count;
  int pulses;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
    m_pulse = 0; m_busy = 0; m_count = 0;
  endtask

  task automatic model_edge(input int b);
    int seen;
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    m_pulse = 0;
    if (seen != m_level) begin
      m_run++;
      if (m_run == SC + 1) begin
        m_level = seen;
        m_run = 0;
        if (seen == 1) begin
          m_pulse = 1;
          m_count = (m_count + 1) % (1 << PW);
        end
      end
    end else begin
      m_run = 0;
    end
    m_busy = (m_run != 0) ? 1 : 0;
  endtask

  task automatic tick(input logic b);
    bus.btn_in = b;
    @(posedge clk);
    model_edge(int'(b));
    #1;
    check("level", int'(bus.btn_level), m_level);
    check("pulse", int'(bus.btn_pulse), m_pulse);
    check("busy", int'(bus.busy), m_busy);
    check("count", int'(bus.press_count), m_count);
    pulses += int'(bus.btn_pulse);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_level", int'(bus.btn_level), 0);
    check("rst_pulse", int'(bus.btn_pulse), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_count", int'(bus.press_count), 0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
  endtask

  initial begin
    bus.btn_in = 1'b0;
    model_reset();
    pulses = 0;
    #12;
    do_reset();

    // clean press
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1);
      check("cp_level", int'(bus.btn_level), (k >= 7) ? 1 : 0);
      check("cp_pulse", int'(bus.btn_pulse), (k == 7) ? 1 : 0);
      check("cp_busy", int'(bus.busy), (k >= 3 && k <= 6) ? 1 : 0);
    end
    check("cp_count", int'(bus.press_count), 1);

    // bounce on press
    do_reset();
    for (int k = 0; k < 3; k++) tick(1'b1);
    tick(1'b0);
    for (int k = 0; k < 12; k++) tick(1'b1);
    check("bp_pulses", pulses, 1);
    check("bp_count", int'(bus.press_count), 1);

    // bounce on release
    tick(1'b0);
    tick(1'b0);
    for (int k = 0; k < 6; k++) tick(1'b1);
    check("br_hold", int'(bus.btn_level), 1);
    check("br_pulses", pulses, 1);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0);
      check("br_level", int'(bus.btn_level), (k >= 7) ? 0 : 1);
    end

    // long hold
    do_reset();
    for (int k = 0; k < 100; k++) tick(1'b1);
    check("lh_pulses", pulses, 1);
    for (int k = 0; k < 8; k++) tick(1'b0);

    // counter wrap
    do_reset();
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 8; k++) tick(1'b1);
      check("wrap", int'(bus.press_count), (i + 1) % 8);
      for (int k = 0; k < 8; k++) tick(1'b0);
    end

    // asynchronous reset mid-qualification
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b1);
    check("mr_busy_pre", int'(bus.busy), 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("mr_level", int'(bus.btn_level), 0);
    check("mr_busy", int'(bus.busy), 0);
    check("mr_count", int'(bus.press_count), 0);
    #2;
    reset = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1);
      check("mr_pulse", int'(bus.btn_pulse), (k == 7) ? 1 : 0);
    end

    // random bursts
    do_reset();
    for (int i = 0; i < 120; i++) begin
      logic b;
      int len;
      b = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) tick(b);
    end
    for (int k = 0; k < 10; k++) tick(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
